debug_tx_serializer: RTL and testbench

//  Downstream of the debug output buffer: accepts one parallel WIDTH-bit debug word per

---
 rtl/debug_tx_serializer_if.sv | 20 ++
 rtl/debug_tx_serializer.sv | 157 +++++++++++++++
 tb/tb_debug_tx_serializer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// debug_tx_serializer_if
//   Word handshake between the debug output buffer (master) and the serial
//   transmitter (slave). The master holds in_data/in_valid until a clock edge
//   at which in_ready is high.
//
//   in_data   master -> slave  WIDTH  word to transmit
//   in_valid  master -> slave  1      in_data is valid
//   in_ready  slave  -> master 1      slave accepts a word on this cycle
// ---------------------------------------------------------------------------
interface debug_tx_serializer_if #(
    parameter int WIDTH = 13
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/debug_tx_serializer.sv
// ---------------------------------------------------------------------------
// debug_tx_serializer
//   Takes one parallel debug word per handshake and sends it on txd as an
//   asynchronous frame: start bit (0), WIDTH data bits LSB first, optional
//   even-parity bit, stop bit (1). Every bit lasts div_q+1 clk cycles, where
//   div_q is clkdiv captured when the word is accepted.
//
//   clk         in   1          system clock, rising edge
//   rst_n       in   1          asynchronous active-low reset
//   clkdiv      in   DIV_WIDTH  bit period minus one, sampled at acceptance
//   in_if       slave modport   in_data / in_valid / in_ready handshake
//   txd         out  1          serial line, idles high
//   busy        out  1          a frame is on the line
//   frame_done  out  1          one-cycle pulse after the stop bit completes
// ---------------------------------------------------------------------------
module debug_tx_serializer #(
    parameter int WIDTH     = 13,
    parameter int DIV_WIDTH = 16,
    parameter int PARITY_EN = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIV_WIDTH-1:0]     clkdiv,
    debug_tx_serializer_if.slave     in_if,
    output logic                     txd,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [WIDTH-1:0]     shift_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 par_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;
    logic                 bit_end;
    logic                 last_data;

    // txd is registered from the current state, so the line trails the FSM
    // by one cycle. busy_q carries that same one-cycle lag: the FSM is
    // already IDLE while the final stop cycle is still on the line, and the
    // block only reopens (in_ready, frame_done) once the line has caught up.
    assign in_if.in_ready = (state_q == IDLE) && !busy_q && rst_n;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign bit_end        = (cnt_q == div_q);
    assign last_data      = (idx_q == IDX_W'(WIDTH - 1));

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && last_data) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timing and shift register. The counter compares against div_q
    // rather than wrapping, so an all-ones divider gives 2^DIV_WIDTH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            div_q   <= clkdiv;
            shift_q <= in_if.in_data;
            idx_q   <= '0;
            par_q   <= even_parity(in_if.in_data);
        end else if (state_q != IDLE) begin
            if (bit_end) begin
                cnt_q <= '0;
                if (state_q == DATA) begin
                    shift_q <= shift_q >> 1;
                    idx_q   <= idx_q + 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Line driver and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state_q)
                START:   txd_q <= 1'b0;
                DATA:    txd_q <= shift_q[0];
                PARITY:  txd_q <= par_q;
                default: txd_q <= 1'b1;
            endcase
            busy_q <= (state_q != IDLE);
            done_q <= (state_q == IDLE) && busy_q;
        end
    end

endmodule

// File: tb/tb_debug_tx_serializer.sv
module tb_debug_tx_serializer;

    typedef logic bitq_t[$];

    logic        clk;
    logic        rst_n;
    logic [15:0] clkdiv;
    logic [12:0] data;
    logic        vld_a;
    logic        vld_b;
    logic        sel;
    logic        txd_a, busy_a, done_a;
    logic        txd_b, busy_b, done_b;
    logic        txd_s, busy_s, done_s, ready_s;
    int          n_assert;
    int          n_fail;

    debug_tx_serializer_if #(.WIDTH(13)) ifa ();
    debug_tx_serializer_if #(.WIDTH(13)) ifb ();

    assign ifa.in_data  = data;
    assign ifb.in_data  = data;
    assign ifa.in_valid = vld_a;
    assign ifb.in_valid = vld_b;

    debug_tx_serializer #(.WIDTH(13), .DIV_WIDTH(16), .PARITY_EN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clkdiv(clkdiv), .in_if(ifa),
        .txd(txd_a), .busy(busy_a), .frame_done(done_a)
    );

    debug_tx_serializer #(.WIDTH(13), .DIV_WIDTH(16), .PARITY_EN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clkdiv(clkdiv), .in_if(ifb),
        .txd(txd_b), .busy(busy_b), .frame_done(done_b)
    );

    assign txd_s   = sel ? txd_b : txd_a;
    assign busy_s  = sel ? busy_b : busy_a;
    assign done_s  = sel ? done_b : done_a;
    assign ready_s = sel ? ifb.in_ready : ifa.in_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_vld(input bit s, input logic v);
        if (s) vld_b = v;
        else   vld_a = v;
    endtask

    // Expected line level for each cycle of a frame, from the framing rules.
    function automatic bitq_t build(input logic [12:0] w, input int d, input bit pen);
        bitq_t q;
        for (int i = 0; i <= d; i++) q.push_back(1'b0);
        for (int b = 0; b < 13; b++)
            for (int i = 0; i <= d; i++) q.push_back(w[b]);
        if (pen)
            for (int i = 0; i <= d; i++) q.push_back(^w);
        for (int i = 0; i <= d; i++) q.push_back(1'b1);
        return q;
    endfunction

    // mode 0: plain; 1: clkdiv changed to 7 mid-frame; 2: in_valid held with
    // changing in_data while busy.
    task automatic frame(input bit s, input logic [12:0] w, input int d,
                         input bit set_div, input int mode, input string tag);
        bitq_t exp_q;
        int    len;
        int    wt;
        sel   = s;
        exp_q = build(w, d, s);
        len   = exp_q.size();
        data  = w;
        if (set_div) clkdiv = 16'(d);
        set_vld(s, 1'b1);
        wt = 0;
        while (!ready_s && wt < 200) begin
            @(negedge clk);
            wt++;
        end
        chk({tag, "_accept_ready"}, 32'(ready_s), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (mode == 2) data = 13'($urandom);
        else set_vld(s, 1'b0);
        chk({tag, "_k0_txd"}, 32'(txd_s), 32'd1);
        chk({tag, "_k0_ready"}, 32'(ready_s), 32'd0);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (mode == 1 && k == 5) clkdiv = 16'd7;
            if (mode == 2) data = 13'($urandom);
            chk($sformatf("%s_txd_k%0d", tag, k), 32'(txd_s), 32'(exp_q[k-1]));
            chk($sformatf("%s_busy_k%0d", tag, k), 32'(busy_s), 32'd1);
            chk($sformatf("%s_done_k%0d", tag, k), 32'(done_s), 32'd0);
            chk($sformatf("%s_ready_k%0d", tag, k), 32'(ready_s), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_end_done"}, 32'(done_s), 32'd1);
        chk({tag, "_end_busy"}, 32'(busy_s), 32'd0);
        chk({tag, "_end_txd"}, 32'(txd_s), 32'd1);
        chk({tag, "_end_ready"}, 32'(ready_s), 32'd1);
        set_vld(s, 1'b0);
    endtask

    initial begin
        logic [12:0] w5;
        logic [12:0] wmax;
        n_assert = 0;
        n_fail   = 0;
        sel      = 1'b0;
        rst_n    = 1'b0;
        vld_a    = 1'b1;
        vld_b    = 1'b1;
        data     = 13'h1A5B;
        clkdiv   = 16'd3;

        // Reset with in_valid asserted
        repeat (3) @(negedge clk);
        chk("rst_txd_a", 32'(txd_a), 32'd1);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_ready_a", 32'(ifa.in_ready), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_txd_b", 32'(txd_b), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_ready_b", 32'(ifb.in_ready), 32'd0);
        chk("rst_done_b", 32'(done_b), 32'd0);
        vld_a = 1'b0;
        vld_b = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_a", 32'(ifa.in_ready), 32'd1);
        chk("rel_ready_b", 32'(ifb.in_ready), 32'd1);
        chk("rel_txd_a", 32'(txd_a), 32'd1);

        // No parity, 4-cycle bits
        frame(1'b0, 13'h1A5B, 3, 1'b1, 0, "t2");

        // Parity, 1-cycle bits, back-to-back on the frame_done cycle
        frame(1'b1, 13'h1A5B, 0, 1'b1, 0, "t3a");
        frame(1'b1, 13'h0001, 0, 1'b1, 0, "t3b");

        // All-zero word
        frame(1'b0, 13'h0000, 1, 1'b1, 0, "zero");

        // clkdiv change mid-frame only affects the next frame
        frame(1'b0, 13'($urandom), 3, 1'b1, 1, "t4a");
        frame(1'b0, 13'($urandom), 7, 1'b0, 0, "t4b");

        // in_valid held with changing data while busy
        frame(1'b0, 13'($urandom), 2, 1'b1, 2, "t6");

        // Reset during DATA bit 5
        sel    = 1'b0;
        w5     = 13'($urandom) & ~13'h0020;
        data   = w5;
        clkdiv = 16'd3;
        chk("t5_ready", 32'(ifa.in_ready), 32'd1);
        vld_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld_a = 1'b0;
        repeat (26) @(negedge clk);
        chk("t5_bit5_txd", 32'(txd_a), 32'(w5[5]));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_txd", 32'(txd_a), 32'd1);
        chk("t5_async_busy", 32'(busy_a), 32'd0);
        chk("t5_async_ready", 32'(ifa.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_idle_txd_%0d", i), 32'(txd_a), 32'd1);
            chk($sformatf("t5_idle_busy_%0d", i), 32'(busy_a), 32'd0);
        end
        frame(1'b0, 13'($urandom), 3, 1'b1, 0, "t5_new");

        // Random frames on both variants
        for (int i = 0; i < 4; i++) begin
            frame(1'($urandom_range(0, 1)), 13'($urandom), int'($urandom_range(0, 3)),
                  1'b1, 0, $sformatf("rnd%0d", i));
        end

        // All-ones divider: start bit must last 65536 cycles
        sel    = 1'b0;
        wmax   = 13'($urandom) | 13'h0001;
        data   = wmax;
        clkdiv = 16'hFFFF;
        vld_a  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld_a = 1'b0;
        @(negedge clk);
        chk("max_first_txd", 32'(txd_a), 32'd0);
        repeat (65535) @(negedge clk);
        chk("max_last_start_txd", 32'(txd_a), 32'd0);
        chk("max_busy", 32'(busy_a), 32'd1);
        @(negedge clk);
        chk("max_bit0_txd", 32'(txd_a), 32'(wmax[0]));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("max_abort_txd", 32'(txd_a), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
